// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs: registered N-input priority encoder with sticky request capture,
// valid/ready output and optional round-robin priority.
module prio_encoder_hs #(
  parameter int N  = 8,
  parameter int W  = $clog2(N),
  parameter bit RR = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ei,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] y,
  output logic         gs,
  output logic         eo
);
  logic [N-1:0] pending_q, pending_d, eligible;
  logic [W-1:0] y_q, y_d, ptr_q, ptr_d, ptr_s, sel, fix_sel, rr_sel, idx;
  logic         valid_q, valid_d, eo_q, eo_d, accept, load;
  assign eligible = pending_q | req;
  assign accept   = valid_q & out_ready;
  assign load     = ei & (~valid_q | accept) & (|eligible);
  // a pointer outside 0..N-1 (non-power-of-two N) is treated as N-1
  assign ptr_s    = (ptr_q > W'(N-1)) ? W'(N-1) : ptr_q;
  always_comb begin
    fix_sel = '0;
    for (int i = 0; i < N; i++)
      if (eligible[i]) fix_sel = W'(i);
  end
  // scan from farthest to nearest so the first hit below ptr_s wins
  always_comb begin
    rr_sel = '0;
    idx    = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = (int'(ptr_s) >= k) ? W'(int'(ptr_s) - k) : W'(int'(ptr_s) + N - k);
      if (eligible[idx]) rr_sel = idx;
    end
  end
  assign sel = RR ? rr_sel : fix_sel;
  always_comb begin
    pending_d = load ? (eligible & ~({{(N-1){1'b0}}, 1'b1} << sel)) : eligible;
    valid_d   = load ? 1'b1 : (accept ? 1'b0 : valid_q);
    y_d       = load ? sel : y_q;
    ptr_d     = (RR && load) ? ((sel == '0) ? W'(N-1) : sel - 1'b1) : ptr_q;
    eo_d      = ei & (pending_d == '0) & ~valid_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      eo_q      <= 1'b0;
      ptr_q     <= W'(N-1);
    end else begin
      pending_q <= pending_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      eo_q      <= eo_d;
      ptr_q     <= ptr_d;
    end
  end
  assign out_valid = valid_q;
  assign gs        = valid_q;
  assign y         = y_q;
  assign eo        = eo_q;
endmodule

// File: tb/tb_prio_encoder_hs.sv
// tb_prio_encoder_hs: fixed and round-robin encoders side by side against a behavioural model.
module tb_prio_encoder_hs;
  localparam int N = 8;
  localparam int W = 3;
  logic clk = 1'b0, rst_n = 1'b0, ei = 1'b0, out_ready = 1'b0;
  logic [N-1:0] req = '0;
  logic fv, fg, fe, rv, rg, re;
  logic [W-1:0] fy, ry;
  int nvec = 0, nmiss = 0;
  logic [N-1:0] m_pend [2];
  logic         m_val  [2];
  logic         m_eo   [2];
  int           m_y    [2];
  int           m_ptr  [2];
  prio_encoder_hs #(.N(N), .W(W), .RR(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .ei(ei), .req(req), .out_ready(out_ready),
    .out_valid(fv), .y(fy), .gs(fg), .eo(fe));
  prio_encoder_hs #(.N(N), .W(W), .RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .ei(ei), .req(req), .out_ready(out_ready),
    .out_valid(rv), .y(ry), .gs(rg), .eo(re));
  always #5 clk = ~clk;
  function automatic int pick(logic [N-1:0] e, int ptr, bit rr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = rr ? (ptr - k + N) % N : N - 1 - k;
      if (e[i]) return i;
    end
    return 0;
  endfunction
  task automatic model(int r);
    logic [N-1:0] elig;
    logic acc, ld;
    int s;
    if (!rst_n) begin
      m_pend[r] = '0; m_val[r] = 1'b0; m_y[r] = 0; m_eo[r] = 1'b0; m_ptr[r] = N - 1;
    end else begin
      elig = m_pend[r] | req;
      acc  = m_val[r] & out_ready;
      ld   = ei && (!m_val[r] || acc) && (elig != 0);
      m_pend[r] = elig;
      if (ld) begin
        s = pick(elig, m_ptr[r], r == 1);
        m_y[r] = s;
        m_val[r] = 1'b1;
        m_pend[r][s] = 1'b0;
        if (r == 1) m_ptr[r] = (s + N - 1) % N;
      end else if (acc) m_val[r] = 1'b0;
      m_eo[r] = ei && (m_pend[r] == 0) && !m_val[r];
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmiss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(logic rn, logic e, logic [N-1:0] rq, logic rd);
    rst_n = rn; ei = e; req = rq; out_ready = rd;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    chk("fix_valid", 32'(fv), 32'(m_val[0]));
    chk("fix_y", 32'(fy), 32'(m_y[0]));
    chk("fix_gs", 32'(fg), 32'(m_val[0]));
    chk("fix_eo", 32'(fe), 32'(m_eo[0]));
    chk("rr_valid", 32'(rv), 32'(m_val[1]));
    chk("rr_y", 32'(ry), 32'(m_y[1]));
    chk("rr_gs", 32'(rg), 32'(m_val[1]));
    chk("rr_eo", 32'(re), 32'(m_eo[1]));
  endtask
  initial begin
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    chk("rst_valid", 32'(fv), 0); chk("rst_y", 32'(fy), 0); chk("rst_eo", 32'(fe), 0);
    cyc(1, 1, 8'h00, 1);
    chk("idle_eo", 32'(fe), 1);
    // T1 fixed priority drain
    cyc(1, 1, 8'h26, 1); chk("t1_y5", 32'(fy), 5); chk("t1_gs", 32'(fg), 1);
    cyc(1, 1, 8'h00, 1); chk("t1_y2", 32'(fy), 2);
    cyc(1, 1, 8'h00, 1); chk("t1_y1", 32'(fy), 1);
    cyc(1, 1, 8'h00, 1); chk("t1_valid0", 32'(fv), 0); chk("t1_eo", 32'(fe), 1);
    // T2 backpressure holds y
    cyc(1, 1, 8'h20, 0); chk("t2_y5", 32'(fy), 5);
    cyc(1, 1, 8'h80, 0); chk("t2_hold", 32'(fy), 5); chk("t2_valid", 32'(fv), 1);
    cyc(1, 1, 8'h00, 0); chk("t2_hold2", 32'(fy), 5);
    cyc(1, 1, 8'h00, 1); chk("t2_y7", 32'(fy), 7);
    cyc(1, 1, 8'h00, 1); chk("t2_done", 32'(fv), 0);
    // T3 round-robin alternation from a fresh pointer
    cyc(0, 1, 8'h00, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 8'h81, 1);
      chk("t3_rr_y", 32'(ry), (i % 2 == 0) ? 7 : 0);
    end
    repeat (3) cyc(1, 1, 8'h00, 1);
    chk("t3_drained", 32'(rv), 0);
    // T4 ei gating
    cyc(1, 0, 8'h08, 1); chk("t4_valid0", 32'(fv), 0); chk("t4_eo0", 32'(fe), 0);
    cyc(1, 1, 8'h00, 1); chk("t4_y3", 32'(fy), 3); chk("t4_valid1", 32'(fv), 1);
    cyc(1, 1, 8'h00, 1); chk("t4_eo1", 32'(fe), 1);
    // T5 re-request of the presented index
    cyc(1, 1, 8'h10, 0); chk("t5_y4", 32'(fy), 4);
    cyc(1, 1, 8'h10, 1); chk("t5_again", 32'(fy), 4); chk("t5_valid", 32'(fv), 1);
    cyc(1, 1, 8'h00, 1); chk("t5_done", 32'(fv), 0);
    // T6 reset mid-operation
    cyc(1, 1, 8'hFF, 0); chk("t6_y7", 32'(fy), 7);
    cyc(1, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    chk("t6_valid0", 32'(fv), 0); chk("t6_y0", 32'(fy), 0); chk("t6_eo0", 32'(fe), 0);
    cyc(1, 1, 8'h00, 1); chk("t6_eo1", 32'(fe), 1); chk("t6_rr_eo1", 32'(re), 1);
    // randomized traffic
    repeat (400) begin
      cyc(($urandom % 50) != 0, ($urandom % 8) != 0,
          ($urandom % 3 == 0) ? N'($urandom) : '0, ($urandom % 4) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
